scroller_seq: RTL and testbench
===============================

// Module: scroller_seq
// PURPOSE
//  Sequencer that drives the 2-glyph charrom to render a horizontally scrolling text band.
//  Maps VGA pixel coords + frame-based scroll offset to {sym,yaddr,xaddr}, takes back the
//  3-bit ROM pixel and emits a palette index. Sits between vga timing and the palette
//  lookup; 2-cycle pipeline, scroll state advanced once per frame.
// PARAMETERS
//  MSG_LOG2  4            log2 of message length in glyphs (message = 2**MSG_LOG2 glyphs)
//  MSG       16'hA5C3     glyph pattern, bit i = sym of glyph i (width 2**MSG_LOG2)
//  BAND_Y    10'd224      first scanline of the 32-line text band
//  SPEED     5'd2         scroll pixels per frame, 1..31
//  CYCLE_DIV 3            (COLOR_CYCLE_EN only) rotate colors every 2**CYCLE_DIV frames
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   async reset, active-high
//  hpos         in   10  current pixel x (0..639 visible)
//  vpos         in   10  current pixel y (0..479 visible)
//  active       in   1   hpos/vpos inside visible area
//  frame_start  in   1   1-cycle pulse at first cycle of vertical blanking
//  pause        in   1   freeze scroll (and color rotation) while high
//  rom_sym      out  1   charrom sym select
//  rom_xaddr    out  5   charrom column
//  rom_yaddr    out  5   charrom row
//  rom_data     in   3   charrom pixel (combinational from rom_* outputs)
//  color        out  3   palette index for pixel presented 2 cycles earlier
//  color_valid  out  1   active delayed by 2 cycles
// BEHAVIOUR
//  - Reset: scroll_x=0, rom_sym/xaddr/yaddr=0, color=0, color_valid=0, pipeline in_band=0.
//  - scroll_x width MSG_LOG2+5; on frame_start & !pause: scroll_x <= scroll_x+SPEED, natural
//    wrap mod 32*2**MSG_LOG2. pause & frame_start same cycle: no change.
//  - Stage 1 (register at clk): wx = hpos + scroll_x (trunc to MSG_LOG2+5 bits);
//    dy = vpos - BAND_Y (10 bit); in_band1 = active & (vpos>=BAND_Y) & (vpos<BAND_Y+32).
//    rom_xaddr<=wx[4:0]; rom_yaddr<=dy[4:0]; rom_sym<=MSG[wx[MSG_LOG2+4:5]];
//    valid1<=active. Outside band address regs still update (don't-care, rom_data ignored).
//  - Stage 2: color <= in_band1 ? rom_data : 3'd0; color_valid <= valid1.
//  - Latency: pixel at (hpos,vpos) on cycle N -> color on cycle N+2. No stalls, no handshake;
//    one new pixel accepted every cycle.
//  - rom_data value 0 is transparent/background and always maps to color 0.
//  - Band crossing BAND_Y+31 -> BAND_Y+32: color forced 0 from that pixel's N+2 onward.
//  - scroll_x change mid-line impossible in normal use (frame_start in blanking); if pulsed
//    mid-line the new offset applies to pixels sampled from next cycle.
//  - rst mid-frame: all regs cleared immediately; first valid color 2 cycles after release.
// CONFIGURATION
//  COLOR_CYCLE_EN defined: 3-bit rot counter + CYCLE_DIV-bit frame prescaler; on
//   frame_start & !pause prescaler increments, on its wrap rot <= (rot==6)?0:rot+1.
//   Stage 2 nonzero rom_data d -> color = ((d-1+rot) mod 7)+1; 0 stays 0. rot resets to 0.
//  COLOR_CYCLE_EN undefined: no rot/prescaler logic; color = rom_data pass-through as above.
// TESTING
//  1 reset: rst=1 mid-line, any inputs -> color=0, color_valid=0, rom_*=0, scroll_x=0.
//  2 latency: scroll_x=0, vpos=230, hpos=37, active=1 -> next cycle rom_xaddr=5,
//    rom_yaddr=6, rom_sym=MSG[1]; with rom_data model = sym?5:2, color at N+2 = that value.
//  3 band edge: vpos=223 and vpos=256 -> color=0 regardless of rom_data; vpos=255 -> rom_yaddr=31.
//  4 scroll: 3 frame_start pulses with SPEED=2 -> scroll_x=6; hpos=26 -> rom_xaddr=0,
//    rom_sym=MSG[1]; 256 pulses total (2*256=512=wrap) -> scroll_x=0.
//  5 pause: pause=1 with frame_start -> scroll_x unchanged; pause drop then pulse -> +SPEED.
//  6 COLOR_CYCLE_EN, CYCLE_DIV=0: after 1 frame rom_data=7 -> color=1, rom_data=0 -> 0;
//    after 7 frames rot back to 0, color=7.

Source files
------------

// File: rtl/scroller_seq.sv
// Scrolling text-band sequencer: maps pixel coordinates plus a per-frame scroll offset onto
// charrom addresses and turns the returned pixel into a palette index (2-cycle pipeline).
// Optional color rotation is enabled by defining COLOR_CYCLE_EN.
module scroller_seq #(
  parameter int                     MSG_LOG2  = 4,
  parameter logic [2**MSG_LOG2-1:0] MSG       = 16'hA5C3,
  parameter logic [9:0]             BAND_Y    = 10'd224,
  parameter logic [4:0]             SPEED     = 5'd2,
  parameter int                     CYCLE_DIV = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       active,
  input  logic       frame_start,
  input  logic       pause,
  output logic       rom_sym,
  output logic [4:0] rom_xaddr,
  output logic [4:0] rom_yaddr,
  input  logic [2:0] rom_data,
  output logic [2:0] color,
  output logic       color_valid
);
  localparam int SW = MSG_LOG2 + 5;

  logic [SW-1:0] scroll_x;
  logic [SW-1:0] wx;
  logic [9:0]    dy;
  logic          in_band;
  logic          in_band1;
  logic          valid1;
  logic [2:0]    mapped;
  logic [2:0]    color_next;

  assign wx = SW'(hpos) + scroll_x;
  assign dy = vpos - BAND_Y;
  // 11-bit compare so a band near the top of the 10-bit range cannot wrap
  assign in_band = active && ({1'b0, vpos} >= {1'b0, BAND_Y}) &&
                   ({1'b0, vpos} < ({1'b0, BAND_Y} + 11'd32));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll_x <= '0;
    end else if (frame_start && !pause) begin
      scroll_x <= scroll_x + SW'(SPEED);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_xaddr <= 5'd0;
      rom_yaddr <= 5'd0;
      rom_sym   <= 1'b0;
      in_band1  <= 1'b0;
      valid1    <= 1'b0;
    end else begin
      rom_xaddr <= wx[4:0];
      rom_yaddr <= dy[4:0];
      rom_sym   <= MSG[wx[SW-1:5]];
      in_band1  <= in_band;
      valid1    <= active;
    end
  end

`ifdef COLOR_CYCLE_EN
  localparam int             PW   = (CYCLE_DIV > 0) ? CYCLE_DIV : 1;
  localparam logic [PW-1:0]  PMAX = PW'((2 ** CYCLE_DIV) - 1);

  logic [PW-1:0] presc;
  logic [2:0]    rot;
  logic [3:0]    sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      rot   <= 3'd0;
    end else if (frame_start && !pause) begin
      if (presc == PMAX) begin
        presc <= '0;
        rot   <= (rot == 3'd6) ? 3'd0 : rot + 3'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Nonzero colors 1..7 rotate among themselves; 0 is background and never rotated
  always_comb begin
    sum = {1'b0, rom_data} - 4'd1 + {1'b0, rot};
    if (sum >= 4'd7) sum = sum - 4'd7;
    mapped = sum[2:0] + 3'd1;
  end
`else
  assign mapped = rom_data;
`endif

  always_comb begin
    color_next = 3'd0;
    if (in_band1 && (rom_data != 3'd0)) color_next = mapped;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color       <= 3'd0;
      color_valid <= 1'b0;
    end else begin
      color       <= color_next;
      color_valid <= valid1;
    end
  end
endmodule

// File: tb/tb_scroller_seq.sv
// Directed bench for scroller_seq: reset, latency, band edges, scrolling, pause, async reset
// and (when COLOR_CYCLE_EN is defined) color rotation.
module tb_scroller_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos, vpos;
  logic       active, frame_start, pause;
  logic       rom_sym;
  logic [4:0] rom_xaddr, rom_yaddr;
  logic [2:0] rom_data, color;
  logic       color_valid;
  logic       force_en;
  logic [2:0] force_val;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // charrom stand-in: glyph 1 draws color 5, glyph 0 draws color 2
  assign rom_data = force_en ? force_val : (rom_sym ? 3'd5 : 3'd2);

  scroller_seq #(.CYCLE_DIV(0)) dut (
    .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos), .active(active),
    .frame_start(frame_start), .pause(pause), .rom_sym(rom_sym),
    .rom_xaddr(rom_xaddr), .rom_yaddr(rom_yaddr), .rom_data(rom_data),
    .color(color), .color_valid(color_valid)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One active pixel followed by an idle cycle; checks ROM address then resulting color
  task automatic pix(input string tag, input logic [9:0] h, input logic [9:0] v,
                     input bit chk_addr, input int ex, input int ey, input int esym,
                     input int ecol);
    hpos = h; vpos = v; active = 1'b1;
    tick();
    if (chk_addr) begin
      check({tag, " xaddr"}, rom_xaddr, ex);
      check({tag, " yaddr"}, rom_yaddr, ey);
      check({tag, " sym"}, rom_sym, esym);
    end
    active = 1'b0;
    tick();
    check({tag, " color"}, color, ecol);
    check({tag, " valid"}, color_valid, 1);
  endtask

  task automatic frames(input int n, input logic p);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1; pause = p;
      tick();
    end
    frame_start = 1'b0; pause = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hpos = 10'd100; vpos = 10'd230; active = 1'b1;
    frame_start = 1'b0; pause = 1'b0; force_en = 1'b0; force_val = 3'd0;
    tick(); tick();
    check("reset color", color, 0);
    check("reset valid", color_valid, 0);
    check("reset xaddr", rom_xaddr, 0);
    check("reset yaddr", rom_yaddr, 0);
    check("reset sym", rom_sym, 0);
    check("reset scroll", dut.scroll_x, 0);

    // latency: first valid output two cycles after release
    rst = 1'b0; hpos = 10'd37; vpos = 10'd230; active = 1'b1;
    tick();
    check("lat xaddr", rom_xaddr, 5);
    check("lat yaddr", rom_yaddr, 6);
    check("lat sym", rom_sym, 1);
    check("lat valid N+1", color_valid, 0);
    active = 1'b0; hpos = 10'd64;
    tick();
    check("lat color N+2", color, 5);
    check("lat valid N+2", color_valid, 1);

    // band edges and glyph selection across the line
    pix("above band", 10'd37, 10'd223, 1'b1, 5, 31, 1, 0);
    pix("band top", 10'd37, 10'd224, 1'b1, 5, 0, 1, 5);
    pix("band last", 10'd37, 10'd255, 1'b1, 5, 31, 1, 5);
    pix("below band", 10'd37, 10'd256, 1'b1, 5, 0, 1, 0);
    pix("glyph0", 10'd0, 10'd230, 1'b1, 0, 6, 1, 5);
    pix("glyph2", 10'd64, 10'd230, 1'b1, 0, 6, 0, 2);
    pix("glyph9", 10'd300, 10'd230, 1'b1, 12, 6, 0, 2);
    pix("line end", 10'd639, 10'd230, 1'b1, 31, 6, 0, 2);

    // scrolling and wrap
    frames(3, 1'b0);
    check("scroll 3", dut.scroll_x, 6);
    pix("scrolled", 10'd26, 10'd230, 1'b1, 0, 6, 1, 5);
    frames(253, 1'b0);
    check("scroll wrap", dut.scroll_x, 0);
    pix("wrapped", 10'd37, 10'd230, 1'b1, 5, 6, 1, 5);

    // pause
    frames(4, 1'b1);
    check("paused", dut.scroll_x, 0);
    frames(1, 1'b0);
    check("unpaused", dut.scroll_x, 2);
    pix("after pause", 10'd30, 10'd230, 1'b1, 0, 6, 1, 5);

    // asynchronous reset mid-frame
    hpos = 10'd37; vpos = 10'd230; active = 1'b1;
    tick(); tick();
    check("pre-rst valid", color_valid, 1);
    rst = 1'b1;
    #1;
    check("async rst color", color, 0);
    check("async rst valid", color_valid, 0);
    check("async rst xaddr", rom_xaddr, 0);
    check("async rst scroll", dut.scroll_x, 0);
    tick();
    rst = 1'b0; active = 1'b0;
    tick();

    // color mapping of forced ROM values
    force_en = 1'b1; force_val = 3'd0;
    pix("data0", 10'd0, 10'd230, 1'b0, 0, 0, 0, 0);
`ifdef COLOR_CYCLE_EN
    frames(1, 1'b0);
    force_val = 3'd7;
    pix("rot1 d7", 10'd0, 10'd230, 1'b0, 0, 0, 0, 1);
    force_val = 3'd0;
    pix("rot1 d0", 10'd0, 10'd230, 1'b0, 0, 0, 0, 0);
    frames(2, 1'b1);
    force_val = 3'd3;
    pix("rot1 paused d3", 10'd0, 10'd230, 1'b0, 0, 0, 0, 4);
    frames(6, 1'b0);
    force_val = 3'd7;
    pix("rot0 d7", 10'd0, 10'd230, 1'b0, 0, 0, 0, 7);
`else
    force_val = 3'd7;
    pix("pass d7", 10'd0, 10'd230, 1'b0, 0, 0, 0, 7);
    frames(1, 1'b0);
    force_val = 3'd3;
    pix("pass d3", 10'd0, 10'd230, 1'b0, 0, 0, 0, 3);
`endif
    force_val = 3'd6;
    pix("forced out of band", 10'd0, 10'd300, 1'b0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
